// File: rtl/nmi_index_sweeper.sv
// rtl/nmi_index_sweeper.sv - index sweeper walking 0..last with valid/ready handshake and done pulse

module nBitIncrementor #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic            carryIn,
    output logic [SIZE-1:0] sum,
    output logic            carryOut
);
    localparam int PAIRS = SIZE / 2;

    logic [PAIRS:0] c;

    assign c[0] = carryIn;

    // Two-bit ripple cells; each cell propagates only when both its bits are ones.
    for (genvar i = 0; i < PAIRS; i++) begin : g_pair
        assign sum[2*i]     = a[2*i] ^ c[i];
        assign sum[2*i+1]   = a[2*i+1] ^ (a[2*i] & c[i]);
        assign c[i+1]       = c[i] & a[2*i] & a[2*i+1];
    end

    assign carryOut = c[PAIRS];
endmodule

module nmi_index_sweeper #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [SIZE-1:0] last,
    input  logic            ready,
    output logic [SIZE-1:0] idx,
    output logic            valid,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [SIZE-1:0] idx_q, idx_d;
    logic [SIZE-1:0] last_q, last_d;
    logic [SIZE-1:0] inc_sum;
    logic            inc_carry;

    nBitIncrementor #(.SIZE(SIZE)) u_inc (
        .a        (idx_q),
        .carryIn  (1'b1),
        .sum      (inc_sum),
        .carryOut (inc_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx_q  <= '0;
            last_q <= '0;
        end else begin
            state  <= state_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    last_d  = last;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else if (ready) begin
                    // A carry out means idx is all ones, which can only be last_q; treat it as the end.
                    if (idx_q == last_q || inc_carry) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = inc_sum;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign idx   = idx_q;
    assign valid = (state == S_RUN);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
endmodule

// File: tb/tb_nmi_index_sweeper.sv
// tb/tb_nmi_index_sweeper.sv - self-checking bench for nmi_index_sweeper

module tb_nmi_index_sweeper;
    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] last;
    logic       ready;
    logic [7:0] idx;
    logic       valid;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;
    int xfers;
    int dones;
    int last_xfer_idx;

    // Reference: a sweep is "active" with a current index, or is in its done cycle, or is idle.
    bit m_active;
    bit m_done;
    int m_idx;
    int m_last;

    nmi_index_sweeper #(.SIZE(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .last  (last),
        .ready (ready),
        .idx   (idx),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit s, input bit a, input bit r, input int l, input bit rs);
        if (rs) begin
            m_active = 0; m_done = 0; m_idx = 0; m_last = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (a) begin
                m_active = 0; m_idx = 0;
            end else if (r) begin
                if (m_idx == m_last) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end else if (s) begin
            m_active = 1; m_idx = 0; m_last = l;
        end
    endtask

    task automatic step(input bit s, input bit a, input bit r, input logic [7:0] l, input bit rs);
        start = s; abort = a; ready = r; last = l; rst = rs;
        if (!rs && valid === 1'b1 && r) begin
            xfers++;
            last_xfer_idx = int'(idx);
        end
        @(posedge clk);
        model_update(s, a, r, int'(l), rs);
        #1;
        chk("valid", {31'd0, valid}, {31'd0, m_active});
        chk("busy",  {31'd0, busy},  {31'd0, m_active});
        chk("done",  {31'd0, done},  {31'd0, m_done});
        chk("idx",   {24'd0, idx},   m_idx[31:0]);
        if (done === 1'b1) dones++;
        @(negedge clk);
    endtask

    task automatic clear_counts();
        xfers = 0; dones = 0; last_xfer_idx = -1;
    endtask

    initial begin
        int bp_ready [7];
        int bp_idx   [7];
        int cyc;
        n_checks = 0; n_fail = 0;
        start = 0; abort = 0; ready = 0; last = 0; rst = 1;
        m_active = 0; m_done = 0; m_idx = 0; m_last = 0;
        clear_counts();
        @(negedge clk);

        // Reset
        step(0, 0, 0, 8'd0, 1);
        step(0, 0, 0, 8'd0, 1);

        // Basic sweep, last=4
        clear_counts();
        step(1, 0, 1, 8'd4, 0);
        for (int i = 0; i < 5; i++) begin
            chk("basic_idx", {24'd0, idx}, i);
            step(0, 0, 1, 8'd4, 0);
        end
        chk("basic_done_now", {31'd0, done}, 32'd1);
        step(0, 0, 1, 8'd4, 0);
        chk("basic_xfers", xfers, 32'd5);
        chk("basic_dones", dones, 32'd1);

        // Backpressure, last=3
        bp_ready = '{1, 0, 0, 1, 1, 0, 1};
        bp_idx   = '{0, 1, 1, 1, 2, 3, 3};
        clear_counts();
        step(1, 0, 0, 8'd3, 0);
        for (int i = 0; i < 7; i++) begin
            chk("bp_idx", {24'd0, idx}, bp_idx[i]);
            step(0, 0, bp_ready[i][0], 8'd3, 0);
        end
        step(0, 0, 0, 8'd3, 0);
        chk("bp_xfers", xfers, 32'd4);
        chk("bp_dones", dones, 32'd1);

        // last=0
        clear_counts();
        step(1, 0, 1, 8'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'd0, 0);
        chk("l0_xfers", xfers, 32'd1);
        chk("l0_dones", dones, 32'd1);

        // Full range
        clear_counts();
        step(1, 0, 1, 8'hFF, 0);
        for (int i = 0; i < 258; i++) step(0, 0, 1, 8'hFF, 0);
        chk("full_xfers", xfers, 32'd256);
        chk("full_last_idx", last_xfer_idx, 32'd255);
        chk("full_dones", dones, 32'd1);

        // Abort at idx=3, then restart
        clear_counts();
        step(1, 0, 1, 8'd10, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'd10, 0);
        chk("ab_idx_pre", {24'd0, idx}, 32'd3);
        step(0, 1, 1, 8'd10, 0);
        chk("ab_valid", {31'd0, valid}, 32'd0);
        chk("ab_idx", {24'd0, idx}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'd10, 0);
        chk("ab_dones", dones, 32'd0);
        step(1, 0, 0, 8'd2, 0);
        chk("ab_restart", {24'd0, idx, valid}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'd2, 0);

        // Reset mid-sweep at idx=5
        clear_counts();
        step(1, 0, 1, 8'd20, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'd20, 0);
        chk("rst_idx_pre", {24'd0, idx}, 32'd5);
        step(0, 0, 1, 8'd20, 1);
        chk("rst_outs", {22'd0, idx, valid, busy}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'd20, 0);
        chk("rst_dones", dones, 32'd0);

        // Start held high through RUN and DONE
        step(1, 0, 1, 8'd2, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            step(1, 0, 1, 8'd2, 0);
            cyc++;
        end
        chk("hold_run_len", cyc, 32'd3);
        step(1, 0, 1, 8'd2, 0);
        chk("hold_gap_valid", {31'd0, valid}, 32'd0);
        step(1, 0, 0, 8'd2, 0);
        chk("hold_restart", {24'd0, idx, valid}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'd2, 0);

        // Latch check: last changes 4 -> 1 mid-sweep
        clear_counts();
        step(1, 0, 1, 8'd4, 0);
        step(0, 0, 1, 8'd4, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'd1, 0);
        chk("latch_last_idx", last_xfer_idx, 32'd4);
        chk("latch_xfers", xfers, 32'd5);

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1) == 1, 8'($urandom_range(0, 12)),
                 ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nmi_index_sweeper.md
Name: nmi_index_sweeper

Overview:
- Sequential address/index generator that walks an index from 0 up to a programmed last value, one index per accepted handshake.
- Each step is computed by an instance of nBitIncrementor (SIZE bits); the sweeper registers its sum and drives the result into the LessDistance datapath as the current point index.
- Provides start/abort control, a valid/ready output handshake, and a one-cycle done pulse.

Parameters:
- SIZE, 8, index width in bits. Must be even and at least 2, as required by nBitIncrementor.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- abort  input  1  cancel a sweep in progress; sampled only in RUN
- last  input  SIZE  final index of the sweep; latched on accepted start
- ready  input  1  downstream accepts the current index this cycle
- idx  output  SIZE  current index, registered
- valid  output  1  idx is valid this cycle
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse after the last index is accepted

Behaviour:
- Reset: synchronous on rising clk with rst=1; overrides all other inputs. State<=IDLE, idx<=0, valid<=0, busy<=0, done<=0, last_q<=0.
- State machine: IDLE, RUN, DONE. All outputs are registered, decoded from state/idx with no combinational input-to-output paths.
- IDLE:
  - valid=0, busy=0, done=0.
  - On start=1: last_q<=last, idx<=0, state<=RUN.
  - valid and busy rise in the cycle after start is sampled, so first idx=0 appears one cycle after start.
- RUN:
  - valid=1, busy=1.
  - Transfer occurs on a cycle with valid=1 and ready=1.
  - On transfer with idx!=last_q: idx<=incrementor sum(idx); stay in RUN.
  - On transfer with idx==last_q: state<=DONE; idx holds.
  - No transfer (ready=0): idx and state hold; idx must stay stable while valid=1 and ready=0.
  - start is ignored in RUN.
- Abort:
  - abort=1 in RUN forces state<=IDLE and idx<=0, even if a transfer occurs that same cycle.
  - The transfer still counts as accepted downstream, but done is not pulsed.
  - Abort has priority over the last-index transition.
- DONE:
  - done=1, valid=0, busy=0 for exactly one cycle, then state<=IDLE unconditionally.
  - start asserted while in DONE is ignored and must be re-asserted in IDLE.
  - abort is ignored in DONE.
- Arithmetic:
  - Next index is taken from the nBitIncrementor sum output only; no behavioural "+1".
  - carryOut is unused functionally. It can only be 1 when idx is all ones, which is necessarily last_q, so no wrap past last_q ever occurs.
- Boundaries:
  - last=0: exactly one index (0) is issued, then done.
  - last=2^SIZE-1: sweep covers the full range with no wrap; done follows acceptance of the all-ones index.
- last changing during RUN has no effect, because last_q was latched at start.
- Reset mid-sweep: next cycle is IDLE with all outputs 0 and no done pulse.
- Throughput: with ready held 1, one index per cycle. A sweep of N=last+1 indices spans start cycle, then N RUN cycles, then 1 DONE cycle.

Test Plan:
- Basic sweep (SIZE=8): rst 2 cycles, start with last=4, ready=1.
  - Response: valid high for 5 cycles with idx 0,1,2,3,4; done pulses the cycle after idx=4; busy falls with done.
- Backpressure: last=3, ready pattern 1,0,0,1,1,0,1.
  - Response: idx sequence 0,1,1,1,2,3,3 with idx stable on every ready=0 cycle; exactly 4 transfers; one done pulse.
- Edge ranges:
  - last=0: single idx=0 transfer, then done.
  - last=8'hFF with ready=1: 256 transfers ending at 8'hFF, no wrap to 0 while valid, done one cycle later.
- Abort: last=10, abort asserted in the cycle idx=3 is valid and ready=1.
  - Response: next cycle valid=0, busy=0, idx=0, no done pulse ever; a new start then restarts from idx=0.
- Reset mid-sweep: rst=1 while idx=5 in RUN.
  - Response: next cycle all outputs 0, state IDLE, no done pulse.
- Ignored start: start held high through RUN and DONE.
  - Response: no restart during RUN; after done, with start still high in IDLE, a new sweep begins and idx=0 appears two cycles after the done pulse.
- Latch check: change last from 4 to 1 mid-sweep.
  - Response: sweep still ends at idx=4.
